// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings and helpers for the multiply/divide sequencing unit.
// Op codes and FSM states are fixed by the pipeline's hazard/forwarding logic.
package mdu_ctrl_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MBUSY = 2'd1;
  localparam logic [1:0] ST_DBUSY = 2'd2;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_res_t;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_muldiv(input logic [2:0] op);
    return is_mul(op) || is_div(op);
  endfunction

  function automatic logic is_op(input logic [2:0] op);
    return (op >= OP_MULT) && (op <= OP_MTLO);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the {hi,lo} result.
// Division goes through magnitudes so the most-negative/-1 case is well defined.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  mdu_res_t    cur,
  output mdu_res_t    res
);

  logic        sgn;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] div_by;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    sgn    = is_signed_op(op);
    a_ext  = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext  = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    prod   = a_ext * b_ext;
    a_neg  = sgn & a[31];
    b_neg  = sgn & b[31];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    div_by = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / div_by;
    r_mag  = a_mag % div_by;
    quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;
  end

  always_comb begin
    res = cur;
    unique case (1'b1)
      is_mul(op): res = prod;
      is_div(op): begin
        // Divide by zero leaves HI/LO untouched.
        if (b != 32'd0) begin
          res.hi = rem;
          res.lo = quo;
        end
      end
      default: res = cur;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: busy counter, pending result, HI/LO registers and D stall.
// Results are captured at issue and committed when the busy count expires.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_uses_mdu,
  output logic        busy,
  output logic        stall_d,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        issue_err
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  mdu_res_t         pend_q, pend_d;
  logic             err_q, err_d;

  mdu_res_t cur_res;
  mdu_res_t arith_res;

  assign cur_res = '{hi: hi_q, lo: lo_q};

  mdu_arith u_arith (
    .op  (mdu_op),
    .a   (a),
    .b   (b),
    .cur (cur_res),
    .res (arith_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          unique case (1'b1)
            is_mul(mdu_op): begin
              pend_d  = arith_res;
              cnt_d   = MULT_LOAD;
              state_d = ST_MBUSY;
            end
            is_div(mdu_op): begin
              pend_d  = arith_res;
              cnt_d   = DIV_LOAD;
              state_d = ST_DBUSY;
            end
            mdu_op == OP_MTHI: hi_d = a;
            mdu_op == OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_MBUSY, ST_DBUSY: begin
        // Issues while busy are dropped; only flagged.
        err_d = start & is_op(mdu_op);
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = pend_q.hi;
          lo_d    = pend_q.lo;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign stall_d   = d_uses_mdu & (busy | (start & is_muldiv(mdu_op)));
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign issue_err = err_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: vector table plus stall, error, reset sequences.
// A second instance with MULT_CYCLES=1 covers the single-cycle busy case.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_uses_mdu;
  logic        busy, stall_d, issue_err;
  logic [31:0] hi, lo;
  logic        busy1, stall_d1, issue_err1;
  logic [31:0] hi1, lo1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .a(a), .b(b), .d_uses_mdu(d_uses_mdu), .busy(busy),
    .stall_d(stall_d), .hi(hi), .lo(lo), .issue_err(issue_err)
  );

  mdu_ctrl #(.MULT_CYCLES(1), .DIV_CYCLES(15)) dut1 (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .a(a), .b(b), .d_uses_mdu(d_uses_mdu), .busy(busy1),
    .stall_d(stall_d1), .hi(hi1), .lo(lo1), .issue_err(issue_err1)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] av,
                       input logic [31:0] bv);
    start  = 1'b1;
    mdu_op = op;
    a      = av;
    b      = bv;
    step();
    start  = 1'b0;
    mdu_op = OP_NONE;
    #1;
  endtask

  initial begin
    vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'd3, 32'h0, 32'h0,
                32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h0,
                32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2, 32'h0, 32'h0,
                32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{OP_DIVU,  32'd1234, 32'd0, 32'h11, 32'h22,
                32'h11, 32'h22, 10};
    vecs[4] = '{OP_DIVU,  32'd100, 32'd7, 32'h0, 32'h0,
                32'd2, 32'd14, 10};
    vecs[5] = '{OP_DIV,   32'd7, 32'hFFFFFFFE, 32'h0, 32'h0,
                32'd1, 32'hFFFFFFFD, 10};
    vecs[6] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h9, 32'h9,
                32'h0, 32'h80000000, 10};
    vecs[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h0, 32'h0,
                32'h40000000, 32'h0, 5};
    vecs[8] = '{OP_DIV,   32'hFFFFFFF0, 32'd0, 32'hAAAA, 32'h5555,
                32'hAAAA, 32'h5555, 10};
    vecs[9] = '{OP_MULTU, 32'h12345678, 32'h10, 32'h7, 32'h7,
                32'h1, 32'h23456780, 5};

    reset = 1'b0;
    start = 1'b0;
    mdu_op = OP_NONE;
    a = '0;
    b = '0;
    d_uses_mdu = 1'b0;
    step();
    step();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset err", 32'(issue_err), 32'd0);
    chk("reset stall", 32'(stall_d), 32'd0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      issue(OP_MTHI, vecs[i].pre_hi, 32'd0);
      issue(OP_MTLO, vecs[i].pre_lo, 32'd0);
      chk($sformatf("v%0d pre hi", i), hi, vecs[i].pre_hi);
      chk($sformatf("v%0d pre lo", i), lo, vecs[i].pre_lo);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      for (int c = 1; c <= vecs[i].cyc; c++) begin
        chk($sformatf("v%0d busy c%0d", i, c), 32'(busy), 32'd1);
        chk($sformatf("v%0d hold hi c%0d", i, c), hi, vecs[i].pre_hi);
        step();
      end
      chk($sformatf("v%0d done busy", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("v%0d lo", i), lo, vecs[i].exp_lo);
    end

    // Stall window, illegal issue while busy, then MTHI from idle.
    d_uses_mdu = 1'b1;
    issue(OP_MTHI, 32'h0, 32'd0);
    start = 1'b1; mdu_op = OP_MTHI; a = 32'h77; #1;
    chk("stall mthi idle", 32'(stall_d), 32'd0);
    start = 1'b1; mdu_op = OP_MULT; a = 32'd3; b = 32'd4; #1;
    chk("stall issue", 32'(stall_d), 32'd1);
    chk("busy issue", 32'(busy), 32'd0);
    step();
    start = 1'b0; mdu_op = OP_NONE; #1;
    chk("stall t1", 32'(stall_d), 32'd1);
    chk("busy t1", 32'(busy), 32'd1);
    step();
    start = 1'b1; mdu_op = OP_MTHI; a = 32'h5; #1;
    chk("stall t2", 32'(stall_d), 32'd1);
    step();
    start = 1'b0; mdu_op = OP_NONE; #1;
    chk("err pulse", 32'(issue_err), 32'd1);
    chk("stall t3", 32'(stall_d), 32'd1);
    step();
    chk("err clear", 32'(issue_err), 32'd0);
    chk("stall t4", 32'(stall_d), 32'd1);
    step();
    chk("stall t5", 32'(stall_d), 32'd1);
    chk("busy t5", 32'(busy), 32'd1);
    step();
    chk("stall t6", 32'(stall_d), 32'd0);
    chk("busy t6", 32'(busy), 32'd0);
    chk("mult hi", hi, 32'h0);
    chk("mult lo", lo, 32'd12);
    d_uses_mdu = 1'b0;
    #1;
    issue(OP_MTHI, 32'h5, 32'd0);
    chk("mthi hi", hi, 32'h5);
    chk("mthi busy", 32'(busy), 32'd0);
    chk("mthi err", 32'(issue_err), 32'd0);

    // Reset in busy cycle 4 of a divide abandons the result.
    issue(OP_DIVU, 32'd100, 32'd7);
    step(); step(); step();
    chk("rst busy c4", 32'(busy), 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    for (int c = 0; c < 12; c++) step();
    chk("rst no commit hi", hi, 32'd0);
    chk("rst no commit lo", lo, 32'd0);
    chk("rst no busy", 32'(busy), 32'd0);

    // Reset beats a simultaneous start.
    reset = 1'b0;
    start = 1'b1; mdu_op = OP_MULT; a = 32'd2; b = 32'd2;
    step();
    reset = 1'b1; start = 1'b0; mdu_op = OP_NONE;
    #1;
    chk("rst vs start busy", 32'(busy), 32'd0);
    chk("rst vs start busy1", 32'(busy1), 32'd0);

    // Single-cycle multiply on the MULT_CYCLES=1 instance.
    issue(OP_MULT, 32'd6, 32'd7);
    chk("n1 busy", 32'(busy1), 32'd1);
    chk("n1 hold lo", lo1, 32'd0);
    step();
    chk("n1 idle", 32'(busy1), 32'd0);
    chk("n1 lo", lo1, 32'd42);
    chk("n1 hi", hi1, 32'd0);
    for (int c = 0; c < 5; c++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Sequencing controller for the multiply/divide unit and the HI/LO registers in the 5-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage.
- Models multi-cycle latency with a busy counter and commits results to HI/LO on completion.
- Raises a D-stage stall request while an MDU-using instruction would read stale HI/LO or collide with a running operation.
- Its hi/lo outputs feed the E/M/W HI/LO forwarding paths and mfhi/mflo writeback.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-low reset (reset==0 at a rising edge clears state)
start  in  1  E-stage instruction valid and is an MDU op (not asserted during E-stage bubble)
mdu_op  in  3  E-stage op: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO
a  in  32  E-stage forwarded rs value
b  in  32  E-stage forwarded rt value
d_uses_mdu  in  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
busy  out  1  multi-cycle operation in progress
stall_d  out  1  stall request to hazard unit (combinational)
hi  out  32  architectural HI
lo  out  32  architectural LO
issue_err  out  1  one-cycle pulse: illegal issue while busy

Behaviour:
- Reset (reset==0 at an edge): state IDLE, counter 0, hi=0, lo=0, busy=0, issue_err=0. Reset wins over any simultaneous start. An op in flight is abandoned and its result is never committed.
- States:
  - IDLE: busy=0.
  - MBUSY: busy=1, mult in flight.
  - DBUSY: busy=1, div in flight.
- IDLE, start with MULT/MULTU:
  - Latch the 64-bit product into pending_hi/pending_lo at the edge.
  - MULT is signed×signed; MULTU is zero-extended.
  - Counter loads MULT_CYCLES; next state MBUSY.
- IDLE, start with DIV/DIVU:
  - pending_lo = quotient, pending_hi = remainder.
  - Signed: truncate toward zero; remainder takes the sign of the dividend.
  - Counter loads DIV_CYCLES; next state DBUSY.
  - b==0: pending_hi/lo take the current hi/lo, so the result is unchanged, but the full DIV_CYCLES busy period still elapses.
- IDLE, start with MTHI/MTLO: hi (resp. lo) takes a at the edge; single cycle; busy stays 0.
- MBUSY/DBUSY:
  - Counter decrements each cycle.
  - On the edge where counter==1: hi/lo take pending values, state returns to IDLE, busy falls.
- Timing: start at cycle t → busy=1 during cycles t+1..t+N. New hi/lo visible in cycle t+N+1, the same cycle busy=0.
- start with any op while busy (including MTHI/MTLO):
  - The op is ignored and the running operation is unaffected.
  - issue_err pulses high in the next cycle.
  - The hazard unit must never allow this.
- start with mdu_op==NONE: no effect.
- stall_d = d_uses_mdu & (busy | (start & mdu_op ∈ {MULT,MULTU,DIV,DIVU})).
  - stall_d is combinational with no added latency.
  - It deasserts in the cycle hi/lo become valid.
- hi/lo are plain register outputs; there is no internal bypass of pending values.
- With N=1: busy is high for exactly one cycle.

Decomposition:
- Shared header (alongside the existing forwarding-select macros): mdu_op encodings (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6) and the state encodings (IDLE=0, MBUSY=1, DBUSY=2).
- Sub-module mdu_arith: purely combinational; computes the {hi,lo} result from op, a, b. The controller instantiates it and owns the FSM, counter and register state.

Test Plan:
- MULT: a=0xFFFFFFFE (−2), b=3, start at t → busy high t+1..t+5; at t+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU: a=0xFFFFFFFF, b=2 → after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV: a=−7 (0xFFFFFFF9), b=2 → busy 10 cycles; then lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- DIVU with b=0: preload hi=0x11, lo=0x22 via MTHI/MTLO; busy for 10 cycles; hi/lo remain 0x11/0x22.
- Stall timing: d_uses_mdu=1 held while MULT starts → stall_d=1 in the issue cycle and through t+5, stall_d=0 at t+6. MTHI a=0x5 while busy → issue_err pulse, hi unchanged; MTHI from IDLE → hi=0x5 next cycle with busy=0.
- Reset mid-op: DIV started, reset=0 in busy cycle 4 → next cycle busy=0, hi=lo=0, no later commit.
